// File: rtl/present_key_schedule.sv
// present_key_schedule
//
// Iterative PRESENT-80 key schedule. Holds the 80-bit key register and
// presents the 64-bit round keys K1..K32, one per `next` request.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous, active-high reset
//   load      - one-cycle strobe: capture key_in and restart at round 1
//   key_in    - 80-bit user key, bit 79 is the MSB
//   next      - advance to the next round key
//   round_key - current round key, key_reg[79:16]
//   round_num - round index 1..31; 0 when unloaded or while K32 is shown
//   key_valid - round_key is meaningful
//   done      - high while K32 is presented
//
// All outputs come straight from flops.

module present_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [79:0] key_in,
    input  logic        next,
    output logic [63:0] round_key,
    output logic [4:0]  round_num,
    output logic        key_valid,
    output logic        done
);

    logic [79:0] key_q, key_d;
    logic [5:0]  rcnt_q, rcnt_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic [79:0] rot;
    logic [3:0]  sbox_out;
    logic        advance;

    // Rotate left by 61 is the same as rotate right by 19.
    assign rot = {key_q[18:0], key_q[79:19]};

    always_comb begin
        sbox_out = 4'h0;
        unique case (rot[79:76])
            4'h0: sbox_out = 4'hC;
            4'h1: sbox_out = 4'h5;
            4'h2: sbox_out = 4'h6;
            4'h3: sbox_out = 4'hB;
            4'h4: sbox_out = 4'h9;
            4'h5: sbox_out = 4'h0;
            4'h6: sbox_out = 4'hA;
            4'h7: sbox_out = 4'hD;
            4'h8: sbox_out = 4'h3;
            4'h9: sbox_out = 4'hE;
            4'hA: sbox_out = 4'hF;
            4'hB: sbox_out = 4'h8;
            4'hC: sbox_out = 4'h4;
            4'hD: sbox_out = 4'h7;
            4'hE: sbox_out = 4'h1;
            4'hF: sbox_out = 4'h2;
        endcase
    end

    // Steps are only taken while running; the last key and idle both hold.
    assign advance = next & valid_q & (rcnt_q != 6'd32);

    always_comb begin
        key_d   = key_q;
        rcnt_d  = rcnt_q;
        valid_d = valid_q;
        if (load) begin
            key_d   = key_in;
            rcnt_d  = 6'd1;
            valid_d = 1'b1;
        end else if (advance) begin
            key_d        = {sbox_out, rot[75:0]};
            key_d[19:15] = rot[19:15] ^ rcnt_q[4:0];
            rcnt_d       = rcnt_q + 6'd1;
        end
        // Registered so that done is flop-driven rather than decoded from rcnt.
        done_d = valid_d & (rcnt_d == 6'd32);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q   <= 80'd0;
            rcnt_q  <= 6'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            rcnt_q  <= rcnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign round_key = key_q[79:16];
    assign round_num = rcnt_q[4:0];
    assign key_valid = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_present_key_schedule.sv
// Testbench for present_key_schedule: directed vector table, hand-written
// corner sequences and randomized keys against a software key schedule model.

module tb_present_key_schedule;

    logic        clk;
    logic        rst;
    logic        load;
    logic [79:0] key_in;
    logic        next;
    logic [63:0] round_key;
    logic [4:0]  round_num;
    logic        key_valid;
    logic        done;

    int total;
    int bad;

    present_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .key_in    (key_in),
        .next      (next),
        .round_key (round_key),
        .round_num (round_num),
        .key_valid (key_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    typedef logic [63:0] rk_t [1:32];

    // Software PRESENT-80 key schedule: returns all 32 round keys for a key.
    task automatic make_sched(input logic [79:0] key, output rk_t rk);
        logic [79:0] k;
        logic [79:0] t;
        k = key;
        rk[1] = k[79:16];
        for (int i = 1; i < 32; i++) begin
            t = (k << 61) | (k >> 19);
            t[79:76] = SBOX[t[79:76]];
            t[19:15] = t[19:15] ^ 5'(i);
            k = t;
            rk[i + 1] = k[79:16];
        end
    endtask

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] rk, input logic [4:0] num,
                             input logic vld, input logic dn);
        check({tag, " round_key"}, 80'(round_key), 80'(rk));
        check({tag, " round_num"}, 80'(round_num), 80'(num));
        check({tag, " key_valid"}, 80'(key_valid), 80'(vld));
        check({tag, " done"}, 80'(done), 80'(dn));
    endtask

    // Inputs set before the call are sampled at the coming edge; outputs read 1 ns after.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [79:0] key;
        int          steps;
        logic [63:0] rk;
        logic [4:0]  num;
        logic        vld;
        logic        dn;
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        rk_t         sched;
        logic [79:0] rkey;
        int          idx;
        int          nexts;
        logic        go;

        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        load   = 1'b0;
        key_in = 80'd0;
        next   = 1'b0;

        // Vector table: load a key, issue `steps` nexts, compare outputs.
        vecs[0] = '{"zero k1",  80'd0, 0,  64'h0000000000000000, 5'd1, 1'b1, 1'b0};
        vecs[1] = '{"zero k2",  80'd0, 1,  64'hC000000000000000, 5'd2, 1'b1, 1'b0};
        vecs[2] = '{"zero k3",  80'd0, 2,  64'h5000180000000001, 5'd3, 1'b1, 1'b0};
        vecs[3] = '{"zero k32", 80'd0, 31, 64'h6DAB31744F41D700, 5'd0, 1'b1, 1'b1};
        vecs[4] = '{"zero hold", 80'd0, 32, 64'h6DAB31744F41D700, 5'd0, 1'b1, 1'b1};
        vecs[5] = '{"ones k1",  {80{1'b1}}, 0, 64'hFFFFFFFFFFFFFFFF, 5'd1, 1'b1, 1'b0};
        make_sched({80{1'b1}}, sched);
        vecs[6] = '{"ones k6",  {80{1'b1}}, 5, sched[6], 5'd6, 1'b1, 1'b0};

        // Reset with load held high.
        rst    = 1'b1;
        load   = 1'b1;
        key_in = {$urandom(), $urandom(), 16'($urandom())};
        cycle();
        cycle();
        check_all("reset", 64'd0, 5'd0, 1'b0, 1'b0);
        rst  = 1'b0;
        load = 1'b0;

        // next before any load is ignored.
        next = 1'b1;
        repeat (3) cycle();
        next = 1'b0;
        check_all("idle guard", 64'd0, 5'd0, 1'b0, 1'b0);

        foreach (vecs[v]) begin
            key_in = vecs[v].key;
            load   = 1'b1;
            cycle();
            load = 1'b0;
            next = 1'b1;
            repeat (vecs[v].steps) cycle();
            next = 1'b0;
            check_all(vecs[v].name, vecs[v].rk, vecs[v].num, vecs[v].vld, vecs[v].dn);
        end

        // load and next together at round 7: load wins.
        key_in = 80'd0;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        next = 1'b1;
        repeat (6) cycle();
        check("prio pre num", 80'(round_num), 80'd7);
        key_in = {80{1'b1}};
        load   = 1'b1;
        cycle();
        load = 1'b0;
        check_all("prio k1", 64'hFFFFFFFFFFFFFFFF, 5'd1, 1'b1, 1'b0);
        cycle();
        next = 1'b0;
        make_sched({80{1'b1}}, sched);
        check_all("prio k2", sched[2], 5'd2, 1'b1, 1'b0);

        // Reset mid-run at round 15, then reload.
        rkey   = {$urandom(), $urandom(), 16'($urandom())};
        key_in = rkey;
        load   = 1'b1;
        cycle();
        load = 1'b0;
        next = 1'b1;
        repeat (14) cycle();
        next = 1'b0;
        make_sched(rkey, sched);
        check_all("pre rst", sched[15], 5'd15, 1'b1, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_all("mid rst", 64'd0, 5'd0, 1'b0, 1'b0);
        load = 1'b1;
        cycle();
        load = 1'b0;
        check_all("reload", rkey[79:16], 5'd1, 1'b1, 1'b0);

        // Random keys with random gaps between nexts.
        for (int n = 0; n < 100; n++) begin
            rkey   = {$urandom(), $urandom(), 16'($urandom())};
            make_sched(rkey, sched);
            key_in = rkey;
            load   = 1'b1;
            cycle();
            load = 1'b0;
            idx  = 1;
            check_all("rand load", sched[1], 5'd1, 1'b1, 1'b0);
            nexts = 0;
            // Run past K32 by a few requests to cover the hold.
            while (nexts < 33) begin
                go   = ($urandom_range(0, 2) != 0);
                next = go;
                cycle();
                next = 1'b0;
                if (go) begin
                    nexts++;
                    if (idx < 32) idx++;
                end
                check_all("rand", sched[idx], 5'(idx % 32), 1'b1, idx == 32);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
